// File: rtl/branch_target_sequencer_if.sv
// ============================================================================
// branch_target_sequencer_if
// ----------------------------------------------------------------------------
// Bundles the request handshake, the shared branch-mux select/data pair and
// the response handshake of the branch target sequencer.
//
//   request  : req_valid, req_ready, op[1:0], taken
//   mux      : mux_src[2:0] (sequencer -> mux), mux_data[31:0] (mux -> sequencer)
//   response : resp_valid, resp_ready, next_pc[31:0], link[31:0], link_we,
//              misaligned
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding pipeline (issues requests, owns the mux,
//            consumes responses)
// ============================================================================
interface branch_target_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic        taken;
    logic [2:0]  mux_src;
    logic [31:0] mux_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] next_pc;
    logic [31:0] link;
    logic        link_we;
    logic        misaligned;

    modport slave (
        input  req_valid,
        input  op,
        input  taken,
        input  mux_data,
        input  resp_ready,
        output req_ready,
        output mux_src,
        output resp_valid,
        output next_pc,
        output link,
        output link_we,
        output misaligned
    );

    modport master (
        output req_valid,
        output op,
        output taken,
        output mux_data,
        output resp_ready,
        input  req_ready,
        input  mux_src,
        input  resp_valid,
        input  next_pc,
        input  link,
        input  link_we,
        input  misaligned
    );

endinterface

// File: rtl/branch_target_sequencer.sv
// ============================================================================
// branch_target_sequencer
// ----------------------------------------------------------------------------
// Resolves JAL / JALR / conditional-branch targets using one shared input mux
// and a single 32-bit adder. Each request walks through the states
// IDLE -> LINK -> BASE -> OFFS -> RESP, steering the mux one operand per cycle:
//   LINK : PC+4 captured as the return address
//   BASE : PC (or rs for JALR) captured as the adder base
//   OFFS : offset selected, target computed and the response registered
//   RESP : response held until the consumer accepts it
//
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - asynchronous, active-high reset
//   bus    - branch_target_sequencer_if.slave (request, mux and response)
// ============================================================================
module branch_target_sequencer (
    input  logic                      clk,
    input  logic                      reset,
    branch_target_sequencer_if.slave  bus
);

    // Request kinds
    localparam logic [1:0] OP_JAL    = 2'b00;
    localparam logic [1:0] OP_JALR   = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    // Shared mux select encodings
    localparam logic [2:0] MUX_ZERO  = 3'b000;
    localparam logic [2:0] MUX_PC4   = 3'b001;
    localparam logic [2:0] MUX_PC    = 3'b010;
    localparam logic [2:0] MUX_REG   = 3'b011;
    localparam logic [2:0] MUX_IMM12 = 3'b100;
    localparam logic [2:0] MUX_JOFF  = 3'b101;
    localparam logic [2:0] MUX_BOFF  = 3'b110;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LINK = 3'd1,
        BASE = 3'd2,
        OFFS = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state_q,     state_d;
    logic [1:0]  op_q,        op_d;
    logic        taken_q,     taken_d;
    logic [31:0] link_r_q,    link_r_d;
    logic [31:0] base_q,      base_d;
    logic [31:0] next_pc_q,   next_pc_d;
    logic [31:0] link_q,      link_d;
    logic        link_we_q,   link_we_d;

    logic        req_ready_c;
    logic        resp_valid_c;
    logic [2:0]  mux_src_c;
    logic [31:0] sum;

    // The single adder: base operand from BASE plus whatever offset the mux
    // presents in OFFS. Carry out of bit 31 is intentionally dropped.
    assign sum = base_q + bus.mux_data;

    // Next-state and output decode. op/taken are only sampled in IDLE on
    // acceptance, so later changes on those inputs cannot affect a request
    // already in flight.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        taken_d      = taken_q;
        link_r_d     = link_r_q;
        base_d       = base_q;
        next_pc_d    = next_pc_q;
        link_d       = link_q;
        link_we_d    = link_we_q;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        mux_src_c    = MUX_ZERO;

        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.op;
                    taken_d = bus.taken;
                    state_d = LINK;
                end
            end

            LINK: begin
                mux_src_c = MUX_PC4;
                link_r_d  = bus.mux_data;
                state_d   = BASE;
            end

            BASE: begin
                mux_src_c = (op_q == OP_JALR) ? MUX_REG : MUX_PC;
                base_d    = bus.mux_data;
                state_d   = OFFS;
            end

            OFFS: begin
                link_d  = link_r_q;
                state_d = RESP;
                case (op_q)
                    OP_JAL: begin
                        mux_src_c = MUX_JOFF;
                        next_pc_d = sum;
                        link_we_d = 1'b1;
                    end
                    OP_JALR: begin
                        // JALR targets always have bit 0 forced low
                        mux_src_c = MUX_IMM12;
                        next_pc_d = {sum[31:1], 1'b0};
                        link_we_d = 1'b1;
                    end
                    OP_BRANCH: begin
                        link_we_d = 1'b0;
                        if (taken_q) begin
                            mux_src_c = MUX_BOFF;
                            next_pc_d = sum;
                        end else begin
                            mux_src_c = MUX_ZERO;
                            next_pc_d = link_r_q;
                        end
                    end
                    default: begin
                        // Reserved op falls through to the sequential PC
                        mux_src_c = MUX_ZERO;
                        next_pc_d = link_r_q;
                        link_we_d = 1'b0;
                    end
                endcase
            end

            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything so the block
    // looks freshly powered up and any in-flight request is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 2'b00;
            taken_q   <= 1'b0;
            link_r_q  <= 32'h0;
            base_q    <= 32'h0;
            next_pc_q <= 32'h0;
            link_q    <= 32'h0;
            link_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            taken_q   <= taken_d;
            link_r_q  <= link_r_d;
            base_q    <= base_d;
            next_pc_q <= next_pc_d;
            link_q    <= link_d;
            link_we_q <= link_we_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.mux_src    = mux_src_c;
    assign bus.next_pc    = next_pc_q;
    assign bus.link       = link_q;
    assign bus.link_we    = link_we_q;
    // Flag only; a misaligned target is still delivered as a normal response
    assign bus.misaligned = |next_pc_q[1:0];

endmodule

// File: tb/tb_branch_target_sequencer.sv
// ============================================================================
// tb_branch_target_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for branch_target_sequencer. The bench plays the role
// of the shared branch mux (mux_data follows mux_src combinationally from the
// scenario operands), drives requests from a vector table, pushes expected
// responses to a scoreboard queue and pops/compares them when the response
// appears. Hand-written sequences cover response back-pressure and a reset
// in the middle of a request.
// ============================================================================
module tb_branch_target_sequencer;

    typedef struct packed {
        logic [1:0]  op;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] imm;
        logic [31:0] joff;
        logic [31:0] boff;
        logic [2:0]  mux_base;
        logic [2:0]  mux_offs;
        logic [31:0] exp_next_pc;
        logic [31:0] exp_link;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;

    typedef struct packed {
        logic [31:0] next_pc;
        logic [31:0] link;
        logic        we;
        logic        mis;
    } exp_t;

    localparam int NUM_VECS = 8;

    logic        clk;
    logic        reset;
    logic [31:0] pc_v;
    logic [31:0] rs_v;
    logic [31:0] imm_v;
    logic [31:0] joff_v;
    logic [31:0] boff_v;

    int          checks;
    int          errors;
    vec_t        vecs [NUM_VECS];
    exp_t        sb_q [$];
    exp_t        held;

    branch_target_sequencer_if bus ();

    branch_target_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the shared branch input mux
    always_comb begin
        case (bus.mux_src)
            3'b000:  bus.mux_data = 32'h0;
            3'b001:  bus.mux_data = pc_v + 32'd4;
            3'b010:  bus.mux_data = pc_v;
            3'b011:  bus.mux_data = rs_v;
            3'b100:  bus.mux_data = imm_v;
            3'b101:  bus.mux_data = joff_v;
            3'b110:  bus.mux_data = boff_v;
            default: bus.mux_data = 32'hDEAD_BEEF;
        endcase
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveScenario(input vec_t v);
        pc_v          = v.pc;
        rs_v          = v.rs;
        imm_v         = v.imm;
        joff_v        = v.joff;
        boff_v        = v.boff;
        bus.op        = v.op;
        bus.taken     = v.taken;
        bus.req_valid = 1'b1;
    endtask

    function automatic exp_t expOf(input vec_t v);
        exp_t e;
        e.next_pc = v.exp_next_pc;
        e.link    = v.exp_link;
        e.we      = v.exp_we;
        e.mis     = v.exp_mis;
        return e;
    endfunction

    // Called at a negedge with the DUT expected idle. Returns at the negedge
    // of the LINK cycle with req_valid dropped and op/taken scrambled.
    task automatic applyStimulus(input vec_t v, input string tag);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkEq({tag, " req_ready before accept"}, 32'(bus.req_ready), 32'd1);
        driveScenario(v);
        sb_q.push_back(expOf(v));
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.op        = ~v.op;
        bus.taken     = ~v.taken;
    endtask

    // Starts at the LINK negedge, ends at the first RESP negedge
    task automatic trackSequence(input vec_t v, input string tag);
        checkEq({tag, " mux_src LINK"}, 32'(bus.mux_src), 32'd1);
        checkEq({tag, " req_ready busy"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        checkEq({tag, " mux_src BASE"}, 32'(bus.mux_src), 32'(v.mux_base));
        @(negedge clk);
        checkEq({tag, " mux_src OFFS"}, 32'(bus.mux_src), 32'(v.mux_offs));
        checkEq({tag, " resp_valid early"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        checkEq({tag, " resp_valid at T+4"}, 32'(bus.resp_valid), 32'd1);
    endtask

    // Pops the oldest expectation and compares against the live response
    task automatic checkOutput(input string tag, output exp_t e);
        e = '0;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected a pending entry", tag);
        end else begin
            e = sb_q.pop_front();
            checkEq({tag, " next_pc"},    bus.next_pc,              e.next_pc);
            checkEq({tag, " link"},       bus.link,                 e.link);
            checkEq({tag, " link_we"},    32'(bus.link_we),         32'(e.we));
            checkEq({tag, " misaligned"}, 32'(bus.misaligned),      32'(e.mis));
            checkEq({tag, " mux_src RESP"}, 32'(bus.mux_src),       32'd0);
            checkEq({tag, " req_ready RESP"}, 32'(bus.req_ready),   32'd0);
        end
    endtask

    // With resp_ready high the handshake happens now; one cycle later idle
    task automatic finishHandshake(input string tag);
        @(negedge clk);
        checkEq({tag, " resp_valid after handshake"}, 32'(bus.resp_valid), 32'd0);
        checkEq({tag, " req_ready after handshake"},  32'(bus.req_ready),  32'd1);
        checkEq({tag, " mux_src IDLE"},               32'(bus.mux_src),    32'd0);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;

        //          op     tk   pc            rs           imm          joff         boff         base    offs    next_pc       link          we    mis
        vecs[0] = '{2'b00, 1'b0, 32'h100,      32'h0,       32'h0,       32'h20,      32'h0,       3'b010, 3'b101, 32'h120,      32'h104,      1'b1, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 32'h100,      32'h2001,    32'h10,      32'h0,       32'h0,       3'b011, 3'b100, 32'h2010,     32'h104,      1'b1, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 32'h100,      32'h0,       32'h0,       32'h0,       32'hFFFFFFF8, 3'b010, 3'b110, 32'hF8,      32'h104,      1'b0, 1'b0};
        vecs[3] = '{2'b10, 1'b0, 32'h100,      32'h0,       32'h0,       32'h0,       32'hFFFFFFF8, 3'b010, 3'b000, 32'h104,     32'h104,      1'b0, 1'b0};
        vecs[4] = '{2'b00, 1'b0, 32'h100,      32'h0,       32'h0,       32'h22,      32'h0,       3'b010, 3'b101, 32'h122,      32'h104,      1'b1, 1'b1};
        vecs[5] = '{2'b11, 1'b1, 32'h200,      32'h0,       32'h0,       32'h40,      32'h40,      3'b010, 3'b000, 32'h204,      32'h204,      1'b0, 1'b0};
        vecs[6] = '{2'b00, 1'b0, 32'hFFFFFFF0, 32'h0,       32'h0,       32'h20,      32'h0,       3'b010, 3'b101, 32'h10,       32'hFFFFFFF4, 1'b1, 1'b0};
        vecs[7] = '{2'b01, 1'b0, 32'h300,      32'h1003,    32'hFFFFFFFC, 32'h0,      32'h0,       3'b011, 3'b100, 32'hFFE,      32'h304,      1'b1, 1'b1};

        bus.req_valid  = 1'b0;
        bus.op         = 2'b00;
        bus.taken      = 1'b0;
        bus.resp_ready = 1'b1;
        pc_v   = 32'h0;
        rs_v   = 32'h0;
        imm_v  = 32'h0;
        joff_v = 32'h0;
        boff_v = 32'h0;

        // Reset applied before the first clock edge: outputs must respond
        // asynchronously.
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkEq("reset req_ready",  32'(bus.req_ready),  32'd1);
        checkEq("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        checkEq("reset mux_src",    32'(bus.mux_src),    32'd0);
        checkEq("reset next_pc",    bus.next_pc,         32'd0);
        checkEq("reset link",       bus.link,            32'd0);
        checkEq("reset link_we",    32'(bus.link_we),    32'd0);
        checkEq("reset misaligned", 32'(bus.misaligned), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] running %0d table vectors", NUM_VECS);
        for (int i = 0; i < NUM_VECS; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i], tag);
            trackSequence(vecs[i], tag);
            checkOutput(tag, e);
            finishHandshake(tag);
        end

        // Reset pulsed while the request sits in BASE
        $display("[TB] reset during BASE");
        applyStimulus(vecs[0], "rst");
        @(negedge clk);
        checkEq("rst mux_src BASE", 32'(bus.mux_src), 32'd2);
        #1 reset = 1'b1;
        #1;
        checkEq("rst req_ready",  32'(bus.req_ready),  32'd1);
        checkEq("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        checkEq("rst mux_src",    32'(bus.mux_src),    32'd0);
        checkEq("rst next_pc",    bus.next_pc,         32'd0);
        checkEq("rst link",       bus.link,            32'd0);
        checkEq("rst link_we",    32'(bus.link_we),    32'd0);
        checkEq("rst misaligned", 32'(bus.misaligned), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkEq($sformatf("rst no resp %0d", k), 32'(bus.resp_valid), 32'd0);
            checkEq($sformatf("rst idle %0d", k),    32'(bus.req_ready),  32'd1);
        end
        applyStimulus(vecs[0], "post-rst");
        trackSequence(vecs[0], "post-rst");
        checkOutput("post-rst", e);
        finishHandshake("post-rst");

        // Back-pressure: hold resp_ready low while a new request waits
        $display("[TB] response stall");
        bus.resp_ready = 1'b0;
        applyStimulus(vecs[4], "stall");
        trackSequence(vecs[4], "stall");
        checkOutput("stall", held);
        driveScenario(vecs[1]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkEq($sformatf("stall%0d resp_valid", k), 32'(bus.resp_valid), 32'd1);
            checkEq($sformatf("stall%0d req_ready", k),  32'(bus.req_ready),  32'd0);
            checkEq($sformatf("stall%0d next_pc", k),    bus.next_pc,         held.next_pc);
            checkEq($sformatf("stall%0d link", k),       bus.link,            held.link);
            checkEq($sformatf("stall%0d link_we", k),    32'(bus.link_we),    32'(held.we));
            checkEq($sformatf("stall%0d misaligned", k), 32'(bus.misaligned), 32'(held.mis));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        checkEq("stall release resp_valid", 32'(bus.resp_valid), 32'd0);
        checkEq("stall release req_ready",  32'(bus.req_ready),  32'd1);
        checkEq("stall release mux_src",    32'(bus.mux_src),    32'd0);
        sb_q.push_back(expOf(vecs[1]));
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.op        = ~vecs[1].op;
        bus.taken     = ~vecs[1].taken;
        trackSequence(vecs[1], "pending");
        checkOutput("pending", e);
        finishHandshake("pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
